// File: rtl/mem_access_stage.sv
// MEM-stage data memory unit: byte/half/word loads and stores on an internal
// word RAM with a configurable number of wait states. While an access is in
// flight, stall_out holds the upstream pipeline. Load data appears on
// dataRead_out only in the cycle the access completes.
module mem_access_stage #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead_in,
  input  logic        memWrite_in,
  input  logic [1:0]  memSize_in,
  input  logic        memSigned_in,
  input  logic [31:0] aluRes_in,
  input  logic [31:0] writeData_in,
  output logic [31:0] dataRead_out,
  output logic        stall_out,
  output logic        misalign_out
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);
  localparam bit HAS_WAIT = (WAIT_CYCLES > 0);

  typedef enum logic {IDLE, BUSY} stateT;

  stateT             state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic [31:0]       ram [2**ADDR_W];

  logic [ADDR_W-1:0] wordIdx;
  logic [1:0]        byteOff;
  logic              request, isStore, isHalf, isWord;
  logic              misaligned, goodReq, complete, writeEn;
  logic [31:0]       ramWord, mergedWord, loadWord;
  logic [7:0]        loadByte;
  logic [15:0]       loadHalf;
  logic              unusedAddrBits;

  // Address bits above the RAM depth are ignored, so addresses wrap.
  assign wordIdx        = aluRes_in[ADDR_W+1:2];
  assign byteOff        = aluRes_in[1:0];
  assign unusedAddrBits = ^aluRes_in[31:ADDR_W+2];

  // A write request wins when both read and write are asserted.
  assign request    = memRead_in | memWrite_in;
  assign isStore    = memWrite_in;
  assign isHalf     = (memSize_in == 2'b01);
  assign isWord     = memSize_in[1];
  assign misaligned = (isHalf & byteOff[0]) | (isWord & (byteOff != 2'b00));
  assign goodReq    = request & ~misaligned;

  assign misalign_out = ~rst & request & misaligned;
  assign ramWord      = ram[wordIdx];
  assign writeEn      = complete & isStore;

  // State register and wait counter; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next-state logic: count wait cycles, and drop back to IDLE on a flush.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    unique case (state)
      IDLE: begin
        if (goodReq && HAS_WAIT) begin
          stateNext = BUSY;
          cntNext   = CNT_W'(1);
        end
      end
      BUSY: begin
        if (!goodReq || cnt == CNT_LAST) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // Outputs: stall until the last wait cycle, then flag completion.
  always_comb begin
    stall_out = 1'b0;
    complete  = 1'b0;
    if (!rst && goodReq) begin
      unique case (state)
        IDLE: begin
          if (HAS_WAIT) stall_out = 1'b1;
          else          complete  = 1'b1;
        end
        BUSY: begin
          if (cnt == CNT_LAST) complete  = 1'b1;
          else                 stall_out = 1'b1;
        end
        default: begin
          stall_out = 1'b0;
        end
      endcase
    end
  end

  // Select the addressed lane and extend it for loads.
  always_comb begin
    loadByte = ramWord[{byteOff, 3'b000} +: 8];
    loadHalf = ramWord[{byteOff[1], 4'b0000} +: 16];
    unique case (memSize_in)
      2'b00:   loadWord = {{24{memSigned_in & loadByte[7]}}, loadByte};
      2'b01:   loadWord = {{16{memSigned_in & loadHalf[15]}}, loadHalf};
      default: loadWord = ramWord;
    endcase
    dataRead_out = (complete && !isStore) ? loadWord : 32'h0;
  end

  // Merge store data into the addressed lanes of the current word.
  always_comb begin
    mergedWord = ramWord;
    unique case (memSize_in)
      2'b00:   mergedWord[{byteOff, 3'b000} +: 8]    = writeData_in[7:0];
      2'b01:   mergedWord[{byteOff[1], 4'b0000} +: 16] = writeData_in[15:0];
      default: mergedWord = writeData_in;
    endcase
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (writeEn) ram[wordIdx] <= mergedWord;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: a wait-state instance and a single-cycle
// instance, both checked every cycle against a transaction-level memory model.
module tb_mem_access_stage;

  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead, memWrite, memSigned;
  logic [1:0]  memSize;
  logic [31:0] aluRes, writeData, dataRead;
  logic        stall, misalign;

  logic        zRead, zWrite, zSigned;
  logic [1:0]  zSize;
  logic [31:0] zAddr, zWData, zData;
  logic        zStall, zMis;

  int          checks = 0;
  int          errors = 0;
  bit          checkEn = 1'b0;
  logic        expStall, expMis, expStallZ, expMisZ;
  logic [31:0] expData, expDataZ;
  logic [31:0] model [256];
  logic [31:0] modelZ [16];

  mem_access_stage #(.ADDR_W(8), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst), .memRead_in(memRead), .memWrite_in(memWrite),
    .memSize_in(memSize), .memSigned_in(memSigned), .aluRes_in(aluRes),
    .writeData_in(writeData), .dataRead_out(dataRead), .stall_out(stall),
    .misalign_out(misalign)
  );

  mem_access_stage #(.ADDR_W(4), .WAIT_CYCLES(0)) dutZ (
    .clk(clk), .rst(rst), .memRead_in(zRead), .memWrite_in(zWrite),
    .memSize_in(zSize), .memSigned_in(zSigned), .aluRes_in(zAddr),
    .writeData_in(zWData), .dataRead_out(zData), .stall_out(zStall),
    .misalign_out(zMis)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle, compare both instances against the expected outputs.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("stall", {31'b0, stall}, {31'b0, expStall});
      checkOutput("misalign", {31'b0, misalign}, {31'b0, expMis});
      checkOutput("dataRead", dataRead, expData);
      checkOutput("zStall", {31'b0, zStall}, {31'b0, expStallZ});
      checkOutput("zMisalign", {31'b0, zMis}, {31'b0, expMisZ});
      checkOutput("zDataRead", zData, expDataZ);
    end
  end

  function automatic bit isMisaligned(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b01) return (addr % 2) != 0;
    if (size[1])       return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [1:0] size,
                                            input logic sgn, input logic [31:0] addr);
    logic [31:0] v;
    int sh;
    if (size == 2'b00) begin
      sh = 8 * int'(addr[1:0]);
      v  = (word >> sh) & 32'hFF;
      if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size == 2'b01) begin
      sh = 16 * int'(addr[1]);
      v  = (word >> sh) & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] modelMerge(input logic [31:0] old, input logic [1:0] size,
                                             input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] mask;
    int sh;
    if (size == 2'b00) begin
      sh = 8 * int'(addr[1:0]);
      mask = 32'hFF << sh;
    end else if (size == 2'b01) begin
      sh = 16 * int'(addr[1]);
      mask = 32'hFFFF << sh;
    end else begin
      sh = 0;
      mask = 32'hFFFF_FFFF;
    end
    return (old & ~mask) | ((wdata << sh) & mask);
  endfunction

  // One transaction on the wait-state instance; flushAt>0 drops the request in that cycle.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata, input int flushAt,
                               output logic [31:0] seenData);
    bit req, mis, flushed;
    int nCyc, idx;
    logic [31:0] expLoad;
    req     = rd | wr;
    mis     = req && isMisaligned(size, addr);
    nCyc    = (req && !mis) ? WAIT + 1 : 1;
    idx     = int'(addr[9:2]);
    expLoad = modelLoad(model[idx], size, sgn, addr);
    flushed = 1'b0;
    seenData = 32'h0;
    @(posedge clk); #1;
    memRead = rd; memWrite = wr; memSize = size; memSigned = sgn;
    aluRes = addr; writeData = wdata;
    for (int c = 0; c < nCyc; c++) begin
      if (flushAt > 0 && c == flushAt) begin
        memRead = 1'b0; memWrite = 1'b0;
        expStall = 1'b0; expMis = 1'b0; expData = 32'h0;
        flushed = 1'b1;
        @(negedge clk);
        break;
      end
      expMis   = mis;
      expStall = req && !mis && (c < WAIT);
      expData  = (c == nCyc - 1 && rd && !wr && !mis) ? expLoad : 32'h0;
      @(negedge clk);
      seenData = dataRead;
      if (c < nCyc - 1) begin
        @(posedge clk); #1;
      end
    end
    if (!flushed && wr && !mis) model[idx] = modelMerge(model[idx], size, addr, wdata);
  endtask

  // One single-cycle transaction on the zero-wait instance.
  task automatic applyStimulusZ(input logic rd, input logic wr, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] seenData);
    bit mis;
    int idx;
    mis = (rd | wr) && isMisaligned(size, addr);
    idx = int'(addr[5:2]);
    @(posedge clk); #1;
    zRead = rd; zWrite = wr; zSize = size; zSigned = sgn; zAddr = addr; zWData = wdata;
    expStallZ = 1'b0;
    expMisZ   = mis;
    expDataZ  = (rd && !wr && !mis) ? modelLoad(modelZ[idx], size, sgn, addr) : 32'h0;
    @(negedge clk);
    seenData = zData;
    if (wr && !mis) modelZ[idx] = modelMerge(modelZ[idx], size, addr, wdata);
  endtask

  task automatic idleCycles(input int n);
    @(posedge clk); #1;
    memRead = 1'b0; memWrite = 1'b0; zRead = 1'b0; zWrite = 1'b0;
    expStall = 1'b0; expMis = 1'b0; expData = 32'h0;
    expStallZ = 1'b0; expMisZ = 1'b0; expDataZ = 32'h0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] seen, ad;
    logic        rd, wr, sg;
    logic [1:0]  sz;
    int          op, fl;

    rst = 1'b1;
    memRead = 1'b1; memWrite = 1'b0; memSize = 2'b10; memSigned = 1'b0;
    aluRes = 32'h10; writeData = 32'h0;
    zRead = 1'b0; zWrite = 1'b0; zSize = 2'b00; zSigned = 1'b0; zAddr = 32'h0; zWData = 32'h0;
    expStall = 1'b0; expMis = 1'b0; expData = 32'h0;
    expStallZ = 1'b0; expMisZ = 1'b0; expDataZ = 32'h0;
    checkEn = 1'b1;

    // Outputs stay quiet during reset even with a request pending.
    @(negedge clk);
    #1 aluRes = 32'h13;
    @(negedge clk);
    @(posedge clk); #1;
    memRead = 1'b0;
    rst = 1'b0;
    idleCycles(1);

    for (int i = 0; i < 256; i++) applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, i * 4, $urandom, 0, seen);

    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, seen);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, seen);
    checkOutput("lwDeadbeef", seen, 32'hDEAD_BEEF);

    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_0080, 0, seen);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0, seen);
    checkOutput("lbSigned", seen, 32'hFFFF_FF80);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 0, seen);
    checkOutput("lbUnsigned", seen, 32'h0000_0080);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, seen);
    checkOutput("lwAfterSb", seen, 32'hDEAD_80EF);

    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_8001, 0, seen);
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0, seen);
    checkOutput("lhSigned", seen, 32'hFFFF_8001);
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0, seen);
    checkOutput("lhUnsigned", seen, 32'h0000_8001);

    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 0, seen);
    checkOutput("lwMisalignData", seen, 32'h0);
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_FFFF, 0, seen);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, seen);
    checkOutput("lwAfterMisSh", seen, 32'h8001_80EF);

    // Reset in the middle of a store must abandon it.
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D, 0, seen);
    @(posedge clk); #1;
    memRead = 1'b0; memWrite = 1'b1; memSize = 2'b10; aluRes = 32'h20; writeData = 32'h1234_5678;
    expStall = 1'b1; expMis = 1'b0; expData = 32'h0;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1 checkOutput("rstAsyncStall", {31'b0, stall}, 32'h0);
    memWrite = 1'b0;
    expStall = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idleCycles(1);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, seen);
    checkOutput("lwAfterReset", seen, 32'hCAFE_F00D);

    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'hA5A5_A5A5, 0, seen);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 0, seen);
    checkOutput("lwWrap", seen, 32'hA5A5_A5A5);

    for (int n = 0; n < 300; n++) begin
      op = int'($urandom_range(0, 10));
      rd = (op <= 4) || (op == 9);
      wr = (op >= 5 && op <= 9);
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      ad = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        if (sz == 2'b01) ad[0] = 1'b0;
        if (sz[1])       ad[1:0] = 2'b00;
      end
      fl = ((rd || wr) && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, WAIT)) : 0;
      applyStimulus(rd, wr, sz, sg, ad, $urandom, fl, seen);
    end
    idleCycles(1);

    for (int i = 0; i < 16; i++) applyStimulusZ(1'b0, 1'b1, 2'b10, 1'b0, i * 4, $urandom, seen);
    applyStimulusZ(1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h1122_3344, seen);
    applyStimulusZ(1'b1, 1'b0, 2'b00, 1'b1, 32'hB, 32'h0, seen);
    checkOutput("zLbTop", seen, 32'h0000_0011);
    for (int n = 0; n < 100; n++) begin
      op = int'($urandom_range(0, 10));
      rd = (op <= 4) || (op == 9);
      wr = (op >= 5 && op <= 9);
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      ad = $urandom;
      if ($urandom_range(0, 1) != 0) begin
        if (sz == 2'b01) ad[0] = 1'b0;
        if (sz[1])       ad[1:0] = 2'b00;
      end
      applyStimulusZ(rd, wr, sz, sg, ad, $urandom, seen);
    end
    idleCycles(2);

    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
